// File: rtl/cluster_count_monitor.sv
// cluster_count_monitor: windowed statistics of the per-clock cluster count with a registered snapshot read port
// Ports: clock/reset (async, active-high); cnt_i, overflow_i, enable_i = sample stream;
//        rd_req_i/rd_sel_i = read request and register select; rd_data_o/rd_valid_o = registered read reply.
module cluster_count_monitor #(
  parameter int WINDOW_LOG2 = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] cnt_i,
  input  logic        overflow_i,
  input  logic        enable_i,
  input  logic        rd_req_i,
  input  logic [1:0]  rd_sel_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o
);
  localparam logic [WINDOW_LOG2-1:0] WCNT_ONE = 1;
  logic [WINDOW_LOG2-1:0] wcnt_q, wcnt_d;
  logic [31:0] acc_sum_q, acc_sum_d, snap_sum_q, snap_sum_d;
  logic [10:0] acc_max_q, acc_max_d, snap_max_q, snap_max_d;
  logic [15:0] acc_ovf_q, acc_ovf_d, snap_ovf_q, snap_ovf_d;
  logic [15:0] acc_nz_q, acc_nz_d, snap_nz_q, snap_nz_d;
  logic [15:0] win_done_q, win_done_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        eow;
  logic [32:0] sum_ext;
  logic [31:0] sum_nxt, rd_mux;
  logic [10:0] max_nxt;
  logic [15:0] ovf_nxt, nz_nxt;
  always_comb begin
    eow = enable_i && (wcnt_q == '1);
    sum_ext = {1'b0, acc_sum_q} + {22'b0, cnt_i};
    sum_nxt = sum_ext[32] ? '1 : sum_ext[31:0];
    max_nxt = (cnt_i > acc_max_q) ? cnt_i : acc_max_q;
    ovf_nxt = (overflow_i && acc_ovf_q != '1) ? acc_ovf_q + 16'd1 : acc_ovf_q;
    nz_nxt = (cnt_i != '0 && acc_nz_q != '1) ? acc_nz_q + 16'd1 : acc_nz_q;
    wcnt_d = enable_i ? wcnt_q + WCNT_ONE : wcnt_q;
    // the closing sample goes into the snapshot, the next window starts empty
    acc_sum_d = !enable_i ? acc_sum_q : eow ? '0 : sum_nxt;
    acc_max_d = !enable_i ? acc_max_q : eow ? '0 : max_nxt;
    acc_ovf_d = !enable_i ? acc_ovf_q : eow ? '0 : ovf_nxt;
    acc_nz_d = !enable_i ? acc_nz_q : eow ? '0 : nz_nxt;
    snap_sum_d = eow ? sum_nxt : snap_sum_q;
    snap_max_d = eow ? max_nxt : snap_max_q;
    snap_ovf_d = eow ? ovf_nxt : snap_ovf_q;
    snap_nz_d = eow ? nz_nxt : snap_nz_q;
    win_done_d = win_done_q + {15'd0, eow};
    // reads see registered snapshots, so a read on the closing cycle returns the previous window
    rd_mux = rd_sel_i == 2'd0 ? snap_sum_q :
             rd_sel_i == 2'd1 ? {21'b0, snap_max_q} :
             rd_sel_i == 2'd2 ? {snap_nz_q, snap_ovf_q} : {16'b0, win_done_q};
    rd_data_d = rd_req_i ? rd_mux : rd_data_q;
    rd_valid_d = rd_req_i;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt_q <= '0;
      acc_sum_q <= '0;
      acc_max_q <= '0;
      acc_ovf_q <= '0;
      acc_nz_q <= '0;
      snap_sum_q <= '0;
      snap_max_q <= '0;
      snap_ovf_q <= '0;
      snap_nz_q <= '0;
      win_done_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      acc_sum_q <= acc_sum_d;
      acc_max_q <= acc_max_d;
      acc_ovf_q <= acc_ovf_d;
      acc_nz_q <= acc_nz_d;
      snap_sum_q <= snap_sum_d;
      snap_max_q <= snap_max_d;
      snap_ovf_q <= snap_ovf_d;
      snap_nz_q <= snap_nz_d;
      win_done_q <= win_done_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign rd_data_o = rd_data_q;
  assign rd_valid_o = rd_valid_q;
endmodule
